// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle main controller and the ALU decoder:
// state encodings, opcodes, ALUOp codes and datapath mux select codes.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback,
// drives ALUOp, datapath mux selects and write enables; memory uses mem_ready.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               mem_req,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BEQ:      w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURESULT;
        w_ctrl.ir_write   = mem_ready;
        w_ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.illegal   = ~is_supported_op(op);
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.mem_write  = mem_ready;
      end
      S_EXECUTER: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_RD2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
      end
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a  = SRCA_RD1;
        w_ctrl.alu_src_b  = SRCB_RD2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = Zero;
      end
      default: w_ctrl = '0;
    endcase

    // Reset abandons the instruction in flight: mux selects stay decoded,
    // but nothing may be written or requested.
    if (reset) begin
      w_ctrl.ir_write  = 1'b0;
      w_ctrl.pc_write  = 1'b0;
      w_ctrl.reg_write = 1'b0;
      w_ctrl.mem_write = 1'b0;
      w_ctrl.mem_req   = 1'b0;
      w_ctrl.illegal   = 1'b0;
    end
  end

  assign ALUOp         = w_ctrl.alu_op;
  assign ALUSrcA       = w_ctrl.alu_src_a;
  assign ALUSrcB       = w_ctrl.alu_src_b;
  assign ResultSrc     = w_ctrl.result_src;
  assign AdrSrc        = w_ctrl.adr_src;
  assign IRWrite       = w_ctrl.ir_write;
  assign PCWrite       = w_ctrl.pc_write;
  assign RegWrite      = w_ctrl.reg_write;
  assign MemWrite      = w_ctrl.mem_write;
  assign mem_req       = w_ctrl.mem_req;
  assign illegal_instr = w_ctrl.illegal;
  assign state_dbg     = STATE_W'(r_state);

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each cycle's expected outputs are queued as
// stimulus is driven, the DUT outputs are captured mid-cycle and compared.
module tb_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic       req;
    logic       ill;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, mem_req, illegal_instr;
  logic [3:0] state_dbg;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  out_t exp_q[$];
  out_t obs_q[$];

  always #5 clk = ~clk;

  main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .mem_req(mem_req), .illegal_instr(illegal_instr),
    .state_dbg(state_dbg)
  );

  // Reference output table for a given (known) state and the current inputs.
  function automatic out_t exp_model(input logic [3:0] s, input logic [6:0] o,
                                     input logic mr, input logic z, input logic rst);
    out_t e;
    e = '0;
    e.st = s;
    case (s)
      4'd0:  begin e.req = 1'b1; e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.srca = 2'b01; e.srcb = 2'b01;
                   e.ill = !(o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ); end
      4'd2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      4'd3:  begin e.req = 1'b1; e.adr = 1'b1; end
      4'd4:  begin e.res = 2'b01; e.regw = 1'b1; end
      4'd5:  begin e.req = 1'b1; e.adr = 1'b1; e.memw = mr; end
      4'd6:  begin e.srca = 2'b10; e.aluop = 2'b10; end
      4'd7:  begin e.regw = 1'b1; end
      4'd8:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10; end
      4'd9:  begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
      4'd10: begin e.srca = 2'b10; e.aluop = 2'b01; e.pcw = z; end
      default: e = '0;
    endcase
    if (rst) begin
      e.irw = 1'b0; e.pcw = 1'b0; e.regw = 1'b0; e.memw = 1'b0; e.req = 1'b0; e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic out_t observed();
    return {state_dbg, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
            PCWrite, RegWrite, MemWrite, mem_req, illegal_instr};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, capture the DUT mid-cycle.
  task automatic drive_cycle(input logic [3:0] st, input logic [6:0] o,
                             input logic mr, input logic z, input logic rst);
    op = o; mem_ready = mr; Zero = z; reset = rst;
    exp_q.push_back(exp_model(st, o, mr, z, rst));
    @(negedge clk);
    obs_q.push_back(observed());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, o;
    drive_cycle(4'd0, LW, 1'b1, 1'b0, 1'b1);
    drive_cycle(4'd0, SW, 1'b1, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL reset: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_lw();
    out_t e, o;
    drive_cycle(4'd0, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd2, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd3, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd4, LW, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL lw: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_lw_wait();
    out_t e, o;
    drive_cycle(4'd0, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, LW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd2, LW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd3, LW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd3, LW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd3, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd4, LW, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL lw_wait: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_sw_wait();
    out_t e, o;
    drive_cycle(4'd0, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd0, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd0, SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd2, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd5, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd5, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd5, SW, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd5, SW, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL sw_wait: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_alu_ops();
    out_t e, o;
    drive_cycle(4'd0, RT, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, RT, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd6, RT, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd7, RT, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd0, IT, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, IT, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd8, IT, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd7, IT, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL alu_ops: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_jal();
    out_t e, o;
    drive_cycle(4'd0, JL, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, JL, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd9, JL, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'd7, JL, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL jal: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_beq();
    out_t e, o;
    drive_cycle(4'd0,  BQ, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd1,  BQ, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd10, BQ, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd0,  BQ, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1,  BQ, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd10, BQ, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL beq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_illegal();
    out_t e, o;
    drive_cycle(4'd0, BAD, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd1, BAD, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd0, 7'b0000000, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, 7'b0000000, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd0, 7'b0100111, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL illegal: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    out_t e, o;
    drive_cycle(4'd0, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd2, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd3, LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd4, LW, 1'b1, 1'b0, 1'b1);
    drive_cycle(4'd0, SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1, SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd2, SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd5, SW, 1'b1, 1'b0, 1'b1);
    drive_cycle(4'd0, SW, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL reset_mid: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    drive_cycle(4'd0,  JL, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1,  JL, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd9,  JL, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd7,  JL, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd0,  SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1,  SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd2,  SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd5,  SW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd0,  BQ, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd1,  BQ, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd10, BQ, 1'b1, 1'b1, 1'b0);
    drive_cycle(4'd0,  LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd1,  LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd2,  LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd3,  LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd4,  LW, 1'b1, 1'b0, 1'b0);
    drive_cycle(4'd0,  RT, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin errors++; $display("FAIL back_to_back: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_lw_wait();
    test_alu_ops();
    test_jal();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
Multicycle main controller that sits directly upstream of the ALU decoder: it sequences each instruction through fetch/decode/execute/memory/writeback states and drives ALUOp to the ALU decoder. It also drives the datapath multiplexer selects and write enables. Supported instructions: lw, sw, R-type, I-type ALU, jal, beq. Memory accesses use a ready handshake, so the controller tolerates multi-cycle memory.

Parameters:
STATE_W, 4, width of the state register (11 states used)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; forces FETCH on next rising edge
op  in  7  instruction opcode, bits [6:0] of the latched instruction
Zero  in  1  ALU zero flag, used in the BEQ state
mem_ready  in  1  memory completes the current access this cycle
ALUOp  out  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
AdrSrc  out  1  0 PC, 1 Result
IRWrite  out  1  latch instruction and OldPC
PCWrite  out  1  load PC with Result
RegWrite  out  1  register-file write enable
MemWrite  out  1  data-memory write enable
mem_req  out  1  memory access request
illegal_instr  out  1  one-cycle pulse when DECODE sees an unsupported opcode
state_dbg  out  STATE_W  current state encoding, for debug and verification

Behaviour:
- Moore FSM with one registered state; outputs are decoded combinationally from the state, then qualified as noted below.
- Default for every output is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Encodings 11-15 go to FETCH.
- Reset: state becomes FETCH at the next edge. While reset=1, all enables (IRWrite, PCWrite, RegWrite, MemWrite, mem_req) and illegal_instr are forced to 0. state_dbg shows the current register value. Asserting reset mid-instruction abandons that instruction with no further writes.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=mem_ready and PCWrite=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECUTER
  - 0010011: EXECUTEI
  - 1101111: JAL
  - 1100011: BEQ
  - any other op: FETCH with illegal_instr=1 for this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=mem_ready. Holds until mem_ready, then FETCH. Exactly one MemWrite cycle per store.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next FETCH.
- Latency with zero wait states, in cycles: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- op is sampled only in DECODE and MEMADR; the datapath holds it stable after IRWrite.

Decomposition:
- Shared package holds the opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ).
- It also holds the state encodings and the ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU decoder.
- No sub-module: one next-state block and one output-decode block.

Test Plan:
- Reset for 2 cycles, then lw (op=0000011) with mem_ready=1 -> states_dbg 0,1,2,3,4,0; RegWrite=1 only in state 4; IRWrite one cycle in state 0.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_req=1 throughout, MemWrite=1 in exactly the one cycle mem_ready=1, then FETCH.
- R-type (0110011) -> ALUOp=10 in EXECUTER; RegWrite in ALUWB; 4 cycles total, no MemWrite.
- beq with Zero=1, then beq with Zero=0 -> PCWrite=1 in BEQ for the first, 0 for the second; ALUOp=01 in both.
- op=1111111 in DECODE -> illegal_instr pulses 1 cycle; next state FETCH; RegWrite, MemWrite and PCWrite all stay 0.
- Reset asserted in MEMWB -> RegWrite forced 0 that cycle; state_dbg=0 after the edge.
